// File: rtl/cosim_commit_checker.sv
// Lock-step commit checker for multi-hart co-simulation.
// The golden model is reached through a port-level handshake:
//   spike_step_o/spike_hart_o  step request, high for one cycle (the STEP cycle)
//   spike_*_i                  per-hart next golden commit record, sampled in STEP
//   irq_set_o/irq_hart_o/irq_mip_o  external-interrupt update, one pulse per change
// Ports:
//   clk_i, rst_i (async, active-high), enable_i, halt_on_mismatch_i, cmp_mask_i
//   commit_*_i / commit_ready_o   per-hart RTL commit stream into the record FIFOs
//   ext_irq_i                     mip.MEIP level per hart
//   mismatch_o/_hart_o/_field_o/_count_o, checked_count_o, halted_o   check results
module cosim_commit_checker #(
  parameter int unsigned NUM_HARTS  = 1,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      halt_on_mismatch_i,
  input  logic [3:0]                cmp_mask_i,
  input  logic [NUM_HARTS-1:0]      commit_valid_i,
  output logic [NUM_HARTS-1:0]      commit_ready_o,
  input  logic [NUM_HARTS*XLEN-1:0] commit_pc_i,
  input  logic [NUM_HARTS*5-1:0]    commit_dst_i,
  input  logic [NUM_HARTS-1:0]      commit_wr_valid_i,
  input  logic [NUM_HARTS*XLEN-1:0] commit_data_i,
  input  logic [NUM_HARTS-1:0]      commit_xcpt_i,
  input  logic [NUM_HARTS*6-1:0]    commit_cause_i,
  input  logic [NUM_HARTS-1:0]      ext_irq_i,
  output logic                      spike_step_o,
  output logic [3:0]                spike_hart_o,
  input  logic [NUM_HARTS*64-1:0]   spike_pc_i,
  input  logic [NUM_HARTS*5-1:0]    spike_dst_i,
  input  logic [NUM_HARTS-1:0]      spike_wr_valid_i,
  input  logic [NUM_HARTS*64-1:0]   spike_data_i,
  input  logic [NUM_HARTS-1:0]      spike_xcpt_i,
  input  logic [NUM_HARTS*6-1:0]    spike_cause_i,
  output logic                      irq_set_o,
  output logic [3:0]                irq_hart_o,
  output logic [63:0]               irq_mip_o,
  output logic                      mismatch_o,
  output logic [3:0]                mismatch_hart_o,
  output logic [3:0]                mismatch_field_o,
  output logic [CNT_W-1:0]          mismatch_count_o,
  output logic [31:0]               checked_count_o,
  output logic                      halted_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      dst;
    logic            wr_valid;
    logic [XLEN-1:0] data;
    logic            xcpt;
    logic [5:0]      cause;
  } rtl_rec_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  dst;
    logic        wr_valid;
    logic [63:0] data;
    logic        xcpt;
    logic [5:0]  cause;
  } spk_rec_t;

  typedef enum logic [1:0] {IDLE, STEP, CMP} state_t;

  state_t            state;
  rtl_rec_t          in_rec  [NUM_HARTS];
  spk_rec_t          spk     [NUM_HARTS];
  rtl_rec_t          mem     [NUM_HARTS][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr  [NUM_HARTS];
  logic [PTR_W-1:0]  rd_ptr  [NUM_HARTS];
  logic [PTR_W:0]    cnt     [NUM_HARTS];
  logic [PTR_W:0]    cnt_nxt [NUM_HARTS];
  logic [NUM_HARTS-1:0] push, pop, nonempty, irq_prev, irq_chg;
  logic [HART_W-1:0] arb_q, sel_q, pick, chg_hart;
  logic              found;
  logic [HART_W:0]   idx;
  rtl_rec_t          head, r_q;
  spk_rec_t          s_q;
  logic              both_wr;
  logic [3:0]        diff;

  // Unpack flat per-hart buses into record arrays
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      in_rec[h].pc       = commit_pc_i[h*XLEN +: XLEN];
      in_rec[h].dst      = commit_dst_i[h*5 +: 5];
      in_rec[h].wr_valid = commit_wr_valid_i[h];
      in_rec[h].data     = commit_data_i[h*XLEN +: XLEN];
      in_rec[h].xcpt     = commit_xcpt_i[h];
      in_rec[h].cause    = commit_cause_i[h*6 +: 6];
      spk[h].pc          = spike_pc_i[h*64 +: 64];
      spk[h].dst         = spike_dst_i[h*5 +: 5];
      spk[h].wr_valid    = spike_wr_valid_i[h];
      spk[h].data        = spike_data_i[h*64 +: 64];
      spk[h].xcpt        = spike_xcpt_i[h];
      spk[h].cause       = spike_cause_i[h*6 +: 6];
    end
  end

  // FIFO control; a full FIFO still takes a push when it is popped that cycle
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      pop[h]      = (state == STEP) && (sel_q == HART_W'(h));
      push[h]     = commit_valid_i[h] && (commit_ready_o[h] || pop[h]);
      nonempty[h] = (cnt[h] != '0);
      cnt_nxt[h]  = cnt[h];
      if (push[h] && !pop[h]) cnt_nxt[h] = cnt[h] + (PTR_W+1)'(1);
      if (pop[h] && !push[h]) cnt_nxt[h] = cnt[h] - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int h = 0; h < NUM_HARTS; h++)
      if (push[h]) mem[h][wr_ptr[h]] <= in_rec[h];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        wr_ptr[h] <= '0;
        rd_ptr[h] <= '0;
        cnt[h]    <= '0;
      end
      commit_ready_o <= '1;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (push[h]) wr_ptr[h] <= wr_ptr[h] + PTR_W'(1);
        if (pop[h])  rd_ptr[h] <= rd_ptr[h] + PTR_W'(1);
        cnt[h]            <= cnt_nxt[h];
        commit_ready_o[h] <= (cnt_nxt[h] != (PTR_W+1)'(FIFO_DEPTH));
      end
    end
  end

  assign head = mem[sel_q][rd_ptr[sel_q]];

  // Round-robin pick: first non-empty hart at or after the arbitration pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      idx = (HART_W+1)'(arb_q) + (HART_W+1)'(i);
      if (idx >= (HART_W+1)'(NUM_HARTS)) idx = idx - (HART_W+1)'(NUM_HARTS);
      if (!found && nonempty[HART_W'(idx)]) begin
        found = 1'b1;
        pick  = HART_W'(idx);
      end
    end
  end

  // Lowest-numbered hart whose interrupt level has not been forwarded yet
  always_comb begin
    irq_chg  = ext_irq_i ^ irq_prev;
    chg_hart = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--)
      if (irq_chg[h]) chg_hart = HART_W'(h);
  end

  // Field comparison; data only for real writebacks, cause only under exception
  always_comb begin
    both_wr = r_q.wr_valid && s_q.wr_valid;
    diff[0] = (64'(r_q.pc) != s_q.pc);
    diff[1] = (r_q.wr_valid != s_q.wr_valid) || (both_wr && (r_q.dst != s_q.dst));
    diff[2] = both_wr && (r_q.dst != 5'd0) && (s_q.dst != 5'd0) &&
              (64'(r_q.data) != s_q.data);
    diff[3] = (r_q.xcpt != s_q.xcpt) ||
              (r_q.xcpt && s_q.xcpt && (r_q.cause != s_q.cause));
    diff    = diff & cmp_mask_i;
  end

  // Main sequencer: IDLE -> STEP -> CMP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      arb_q            <= '0;
      sel_q            <= '0;
      r_q              <= '0;
      s_q              <= '0;
      irq_prev         <= '0;
      spike_step_o     <= 1'b0;
      spike_hart_o     <= '0;
      irq_set_o        <= 1'b0;
      irq_hart_o       <= '0;
      irq_mip_o        <= '0;
      mismatch_o       <= 1'b0;
      mismatch_hart_o  <= '0;
      mismatch_field_o <= '0;
      mismatch_count_o <= '0;
      checked_count_o  <= '0;
      halted_o         <= 1'b0;
    end else begin
      spike_step_o <= 1'b0;
      irq_set_o    <= 1'b0;
      mismatch_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            if (irq_chg != '0) begin
              irq_set_o          <= 1'b1;
              irq_hart_o         <= 4'(chg_hart);
              irq_mip_o          <= {52'd0, ext_irq_i[chg_hart], 11'd0};
              irq_prev[chg_hart] <= ext_irq_i[chg_hart];
            end else if (!halted_o && found) begin
              sel_q        <= pick;
              spike_step_o <= 1'b1;
              spike_hart_o <= 4'(pick);
              state        <= STEP;
            end
          end
        end
        STEP: begin
          r_q   <= head;
          s_q   <= spk[sel_q];
          state <= CMP;
        end
        CMP: begin
          checked_count_o <= checked_count_o + 32'd1;
          if (diff != 4'd0) begin
            mismatch_o       <= 1'b1;
            mismatch_hart_o  <= 4'(sel_q);
            mismatch_field_o <= diff;
            if (mismatch_count_o != '1) mismatch_count_o <= mismatch_count_o + CNT_W'(1);
            if (halt_on_mismatch_i) halted_o <= 1'b1;
          end
          arb_q <= (sel_q == HART_W'(NUM_HARTS - 1)) ? '0 : sel_q + HART_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
